// File: rtl/btle_rx_pdu_octet_buf_pkg.sv
// Shared types and constants for the BLE rx PDU octet buffer: FSM encoding, CRC24 and whitening.
// The whitening helper is only used when BTLE_RX_DEWHITEN_EN is defined.
package btle_rx_pdu_octet_buf_pkg;

    localparam int unsigned CRC_STATE_BIT_WIDTH      = 24;
    localparam int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6;
    localparam int unsigned PDU_MEM_ADDR_BIT_WIDTH   = 6;
    localparam int unsigned MAX_PAYLOAD_OCTET        = 62;

    localparam logic [CRC_STATE_BIT_WIDTH-1:0] CRC24_POLY = 24'h00065B;
    // pos6 feeds back into pos0 and pos4
    localparam logic [6:0] WHITEN_TAPS = 7'b0010001;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StCrc,
        StDone
    } rx_state_e;

    function automatic logic [CRC_STATE_BIT_WIDTH-1:0] crc24_step(
        input logic [CRC_STATE_BIT_WIDTH-1:0] crc,
        input logic                           b
    );
        return {crc[CRC_STATE_BIT_WIDTH-2:0], 1'b0} ^ ((crc[CRC_STATE_BIT_WIDTH-1] ^ b) ?
               CRC24_POLY : '0);
    endfunction

    function automatic logic [6:0] whiten_step(input logic [6:0] lfsr);
        return {lfsr[5:0], 1'b0} ^ (lfsr[6] ? WHITEN_TAPS : 7'h0);
    endfunction

endpackage

// File: rtl/btle_rx_pdu_octet_buf_crc24_serial.sv
// Bit-serial BLE CRC24 register: loads a seed, then folds in one bit per enabled cycle.
module btle_rx_pdu_octet_buf_crc24_serial
    import btle_rx_pdu_octet_buf_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [CRC_STATE_BIT_WIDTH-1:0] seed,
    input  logic                           en,
    input  logic                           crc_bit,
    output logic [CRC_STATE_BIT_WIDTH-1:0] crc_state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_state <= '0;
        end else if (load) begin
            crc_state <= seed;
        end else if (en) begin
            crc_state <= crc24_step(crc_state, crc_bit);
        end
    end

endmodule

// File: rtl/btle_rx_pdu_octet_buf.sv
// Writer side of the rx PDU octet RAM: packs LSB-first octets, tracks length, checks CRC24.
// Define BTLE_RX_DEWHITEN_EN to dewhiten the incoming bit stream before packing and CRC.
module btle_rx_pdu_octet_buf
    import btle_rx_pdu_octet_buf_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rx_hit_flag,
    input  logic                                rx_bit,
    input  logic                                rx_bit_valid,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_state_init_bit,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
    output logic                                rx_decode_run,
    output logic                                rx_decode_end,
    output logic                                rx_crc_ok,
    output logic [6:0]                          rx_payload_length,
    input  logic [PDU_MEM_ADDR_BIT_WIDTH-1:0]   rx_pdu_octet_mem_addr,
    output logic [7:0]                          rx_pdu_octet_mem_data
);

    rx_state_e                        state;
    logic [7:0]                       shift_reg;
    logic [2:0]                       bit_cnt;
    logic [6:0]                       octet_idx;
    logic [4:0]                       crc_cnt;
    logic                             crc_match;
    logic [CRC_STATE_BIT_WIDTH-1:0]   crc_state;
    logic [7:0]                       mem [2**PDU_MEM_ADDR_BIT_WIDTH];

    logic       pdu_bit;
    logic       collecting;
    logic       bit_take;
    logic       crc_load;
    logic       crc_en;
    logic       mem_we;
    logic [7:0] octet_next;

    assign collecting = (state == StHeader) || (state == StPayload);
    assign bit_take   = rx_bit_valid && (collecting || (state == StCrc));
    assign crc_load   = (state == StIdle) && rx_hit_flag;
    assign crc_en     = rx_bit_valid && collecting;
    assign octet_next = {pdu_bit, shift_reg[7:1]};
    assign mem_we     = crc_en && (bit_cnt == 3'd7);

`ifdef BTLE_RX_DEWHITEN_EN
    logic [6:0] whiten;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whiten <= '0;
        end else if (crc_load) begin
            whiten <= {rx_channel_number[0], rx_channel_number[1], rx_channel_number[2],
                       rx_channel_number[3], rx_channel_number[4], rx_channel_number[5], 1'b1};
        end else if (bit_take) begin
            whiten <= whiten_step(whiten);
        end
    end

    assign pdu_bit = rx_bit ^ whiten[6];
`else
    logic unused_channel;
    assign unused_channel = ^rx_channel_number;
    assign pdu_bit        = rx_bit;
`endif

    btle_rx_pdu_octet_buf_crc24_serial u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (crc_load),
        .seed      (rx_crc_state_init_bit),
        .en        (crc_en),
        .crc_bit   (pdu_bit),
        .crc_state (crc_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= StIdle;
            shift_reg         <= '0;
            bit_cnt           <= '0;
            octet_idx         <= '0;
            crc_cnt           <= '0;
            crc_match         <= 1'b0;
            rx_decode_run     <= 1'b0;
            rx_decode_end     <= 1'b0;
            rx_crc_ok         <= 1'b0;
            rx_payload_length <= '0;
        end else begin
            rx_decode_end <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (rx_hit_flag) begin
                        state             <= StHeader;
                        shift_reg         <= '0;
                        bit_cnt           <= '0;
                        octet_idx         <= '0;
                        crc_cnt           <= '0;
                        crc_match         <= 1'b1;
                        rx_decode_run     <= 1'b1;
                        rx_crc_ok         <= 1'b0;
                        rx_payload_length <= '0;
                    end
                end
                StHeader, StPayload: begin
                    if (rx_bit_valid) begin
                        shift_reg <= octet_next;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            octet_idx <= octet_idx + 7'd1;
                            if (state == StHeader && octet_idx == 7'd1) begin
                                rx_payload_length <= octet_next[6:0];
                                if (octet_next == 8'd0) begin
                                    state <= StCrc;
                                end else if (octet_next > 8'(MAX_PAYLOAD_OCTET)) begin
                                    // Length error: skip the CRC phase entirely
                                    crc_match <= 1'b0;
                                    state     <= StDone;
                                end else begin
                                    state <= StPayload;
                                end
                            end else if (state == StPayload &&
                                         octet_idx + 7'd1 == rx_payload_length + 7'd2) begin
                                state <= StCrc;
                            end
                        end
                    end
                end
                StCrc: begin
                    if (rx_bit_valid) begin
                        if (pdu_bit != crc_state[5'd23 - crc_cnt]) begin
                            crc_match <= 1'b0;
                        end
                        crc_cnt <= crc_cnt + 5'd1;
                        if (crc_cnt == 5'd23) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    rx_decode_end <= 1'b1;
                    rx_decode_run <= 1'b0;
                    rx_crc_ok     <= crc_match;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // RAM contents are deliberately not reset; a partial packet survives an abort
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[octet_idx[PDU_MEM_ADDR_BIT_WIDTH-1:0]] <= octet_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pdu_octet_mem_data <= '0;
        end else begin
            rx_pdu_octet_mem_data <= mem[rx_pdu_octet_mem_addr];
        end
    end

endmodule

// File: tb/tb_btle_rx_pdu_octet_buf.sv
// Directed bench for btle_rx_pdu_octet_buf: builds PDU bit streams with a reference CRC24
// (and whitening when BTLE_RX_DEWHITEN_EN is defined) and checks outputs and RAM contents.
module tb_btle_rx_pdu_octet_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_hit_flag = 1'b0;
    logic        rx_bit = 1'b0;
    logic        rx_bit_valid = 1'b0;
    logic [23:0] seed_in = '0;
    logic [5:0]  chan = '0;
    logic [5:0]  rd_addr = '0;
    logic        rx_decode_run;
    logic        rx_decode_end;
    logic        rx_crc_ok;
    logic [6:0]  rx_payload_length;
    logic [7:0]  rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int end_cnt = 0;

    logic [7:0] pkt[$];
    logic       stream[$];

    btle_rx_pdu_octet_buf dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rx_hit_flag           (rx_hit_flag),
        .rx_bit                (rx_bit),
        .rx_bit_valid          (rx_bit_valid),
        .rx_crc_state_init_bit (seed_in),
        .rx_channel_number     (chan),
        .rx_decode_run         (rx_decode_run),
        .rx_decode_end         (rx_decode_end),
        .rx_crc_ok             (rx_crc_ok),
        .rx_payload_length     (rx_payload_length),
        .rx_pdu_octet_mem_addr (rd_addr),
        .rx_pdu_octet_mem_data (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_decode_end) end_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_bit       = b;
        rx_bit_valid = 1'b1;
        tick();
        rx_bit_valid = 1'b0;
    endtask

    task automatic read_mem(input logic [5:0] a, output logic [7:0] v);
        rd_addr = a;
        tick();
        v = rd_data;
    endtask

    // Serialise pkt LSB-first, append CRC24 MSB-first; flip one CRC bit if flip in 0..23
    task automatic build(input logic [23:0] s, input int flip);
        logic [23:0] c;
        logic        b;
        logic        fb;
        c = s;
        stream.delete();
        foreach (pkt[i]) begin
            for (int j = 0; j < 8; j++) begin
                b = pkt[i][j];
                stream.push_back(b);
                fb = c[23] ^ b;
                c  = c << 1;
                if (fb) c = c ^ 24'h00065B;
            end
        end
        for (int k = 0; k < 24; k++) begin
            b = c[23 - k];
            if (k == flip) b = ~b;
            stream.push_back(b);
        end
    endtask

    task automatic whiten(input logic [5:0] ch);
        logic [6:0] w;
        logic       p6;
        w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        foreach (stream[i]) begin
            p6 = w[6];
            stream[i] = stream[i] ^ p6;
            w = {w[5], w[4], w[3] ^ p6, w[2], w[1], w[0], p6};
        end
    endtask

    task automatic run_packet(input string tag, input logic [23:0] s, input logic [5:0] ch,
                              input bit gaps, input bit second_hit, input bit rdw,
                              input logic [7:0] rdw_old);
        int start;
        int n;
        start       = end_cnt;
        seed_in     = s;
        chan        = ch;
        rx_hit_flag = 1'b1;
        tick();
        rx_hit_flag = 1'b0;
        check_eq({tag, ".run_hi"}, rx_decode_run, 1'b1);
        foreach (stream[i]) begin
            if (second_hit && i == 40) begin
                rx_hit_flag = 1'b1;
                seed_in     = 24'h123456;
                chan        = 6'd3;
                tick();
                rx_hit_flag = 1'b0;
            end
            send_bit(stream[i]);
            if (rdw && i == 23) check_eq({tag, ".rd_during_wr"}, rd_data, rdw_old);
            if (gaps) repeat (i % 6) tick();
        end
        repeat (3) tick();
        n = 0;
        while (end_cnt == start && n < 700) begin
            send_bit(1'b0);
            n++;
        end
        repeat (2) tick();
        check_eq({tag, ".end_pulses"}, end_cnt - start, 1);
        check_eq({tag, ".run_lo"}, rx_decode_run, 1'b0);
    endtask

    task automatic set_case3();
        pkt = '{8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    endtask

    task automatic check_case3_ram(input string tag);
        logic [7:0] v;
        for (int a = 0; a < 8; a++) begin
            read_mem(6'(a), v);
            check_eq($sformatf("%s.ram%0d", tag, a), v, pkt[a]);
        end
    endtask

    initial begin
        logic [7:0] v;
        int         start;

        repeat (3) tick();
        check_eq("rst.run", rx_decode_run, 1'b0);
        check_eq("rst.end", rx_decode_end, 1'b0);
        check_eq("rst.crc_ok", rx_crc_ok, 1'b0);
        check_eq("rst.len", rx_payload_length, 7'd0);
        check_eq("rst.rd", rd_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        // Empty PDU, good CRC
        pkt = '{8'h02, 8'h00};
        build(24'h555555, -1);
        run_packet("t2", 24'h555555, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t2.crc_ok", rx_crc_ok, 1'b1);
        check_eq("t2.len", rx_payload_length, 7'd0);
        read_mem(6'd0, v); check_eq("t2.ram0", v, 8'h02);
        read_mem(6'd1, v); check_eq("t2.ram1", v, 8'h00);

        // Six-octet payload, one CRC bit corrupted
        set_case3();
        build(24'h555555, 5);
        run_packet("t3", 24'h555555, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t3.crc_ok", rx_crc_ok, 1'b0);
        check_eq("t3.len", rx_payload_length, 7'd6);
        check_case3_ram("t3");

        // Length 63 exceeds the maximum: length error
        pkt = '{8'h00, 8'h3F};
        build(24'h555555, -1);
        run_packet("t4", 24'h555555, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t4.crc_ok", rx_crc_ok, 1'b0);
        check_eq("t4.len", rx_payload_length, 7'd63);

        // Length 62 is the largest accepted: fills the whole RAM
        pkt = '{8'h00, 8'd62};
        for (int i = 0; i < 62; i++) pkt.push_back(8'(i) ^ 8'hA5);
        build(24'hABCDEF, -1);
        run_packet("t62", 24'hABCDEF, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t62.crc_ok", rx_crc_ok, 1'b1);
        check_eq("t62.len", rx_payload_length, 7'd62);
        read_mem(6'd63, v); check_eq("t62.ram63", v, 8'h98);
        read_mem(6'd2, v);  check_eq("t62.ram2", v, 8'hA5);

        // Gapped bits, stray hit mid-packet, read of addr 2 while it is written
        set_case3();
        build(24'h555555, -1);
        rd_addr = 6'd2;
        run_packet("t5", 24'h555555, 6'd0, 1'b1, 1'b1, 1'b1, 8'hA5);
        check_eq("t5.crc_ok", rx_crc_ok, 1'b1);
        check_eq("t5.len", rx_payload_length, 7'd6);
        check_case3_ram("t5");

        // Reset mid-payload aborts without decode_end
        set_case3();
        build(24'h555555, -1);
        seed_in     = 24'h555555;
        rx_hit_flag = 1'b1;
        tick();
        rx_hit_flag = 1'b0;
        for (int i = 0; i < 30; i++) send_bit(stream[i]);
        start = end_cnt;
        rst_n = 1'b0;
        tick();
        check_eq("t1.run", rx_decode_run, 1'b0);
        check_eq("t1.len", rx_payload_length, 7'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        check_eq("t1.no_end", end_cnt - start, 0);
        pkt = '{8'h02, 8'h00};
        build(24'h555555, -1);
        run_packet("t1b", 24'h555555, 6'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("t1b.crc_ok", rx_crc_ok, 1'b1);

        // Whitened case-3 stream on channel 37
        set_case3();
        build(24'h555555, -1);
        whiten(6'd37);
        run_packet("t6", 24'h555555, 6'd37, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef BTLE_RX_DEWHITEN_EN
        check_eq("t6.crc_ok", rx_crc_ok, 1'b1);
        check_eq("t6.len", rx_payload_length, 7'd6);
        check_case3_ram("t6");
`else
        check_eq("t6.crc_ok", rx_crc_ok, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
